// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and colour constants for the 640x480@60 driver.
// Optional feature macro: VGA_COLORBAR_EN (colour-bar test pattern).
package vga_pkg;

    // 640x480 @ 60 Hz timing, in pixel clocks (horizontal) and lines (vertical)
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_DISP  = 640;
    localparam int H_FRONT = 16;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_DISP  = 480;
    localparam int V_FRONT = 10;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    // Width of the pixel position busses and counters
    localparam int POS_W = 10;

    typedef logic [23:0] rgb_t;

    localparam rgb_t WHITE   = 24'hFFFFFF;
    localparam rgb_t BLACK   = 24'h000000;
    localparam rgb_t RED     = 24'hFF0000;
    localparam rgb_t GREEN   = 24'h00FF00;
    localparam rgb_t BLUE    = 24'h0000FF;
    localparam rgb_t YELLOW  = 24'hFFFF00;
    localparam rgb_t CYAN    = 24'h00FFFF;
    localparam rgb_t MAGENTA = 24'hFF00FF;

    // Colour bars in left-to-right screen order
    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    function automatic rgb_t bar_colour(bar_e bar);
        case (bar)
            BAR_WHITE:   return WHITE;
            BAR_YELLOW:  return YELLOW;
            BAR_CYAN:    return CYAN;
            BAR_GREEN:   return GREEN;
            BAR_MAGENTA: return MAGENTA;
            BAR_RED:     return RED;
            BAR_BLUE:    return BLUE;
            default:     return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_driver_if.sv
// Pixel-source request/response bus: the driver requests a position and the
// source answers with RGB888 combinationally in the same cycle.
interface vga_driver_if;
    import vga_pkg::*;

    logic [POS_W-1:0] pixel_xpos;
    logic [POS_W-1:0] pixel_ypos;
    rgb_t             pixel_data;

    // Driver side: issues the position, consumes the colour
    modport master (
        output pixel_xpos,
        output pixel_ypos,
        input  pixel_data
    );

    // Pixel-source side
    modport slave (
        input  pixel_xpos,
        input  pixel_ypos,
        output pixel_data
    );

endinterface

// File: rtl/vga_colorbar.sv
// Eight equal-width vertical colour bars across the active line, selected by
// the active-area column. Only instantiated when VGA_COLORBAR_EN is defined.
module vga_colorbar
    import vga_pkg::*;
#(
    parameter int ACT_W = H_DISP
) (
    input  logic [POS_W-1:0] i_xpos,
    output rgb_t             o_rgb
);

    localparam int BAR_W = ACT_W / 8;

    logic [POS_W-1:0] w_quot;
    logic [2:0]       w_bar_idx;

    // Division by a constant bar width folds to fixed compare logic
    assign w_quot    = i_xpos / POS_W'(BAR_W);
    assign w_bar_idx = w_quot[2:0];
    assign o_rgb     = bar_colour(bar_e'(w_bar_idx));

endmodule

// File: rtl/vga_driver.sv
// VGA timing generator: free-running h/v counters, pixel-position requests to
// the pixel source, and a registered output stage (hs/vs/de/rgb aligned).
// Optional feature macro: VGA_COLORBAR_EN replaces pixel_data with colour bars.
module vga_driver #(
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BACK  = vga_pkg::H_BACK,
    parameter int H_DISP  = vga_pkg::H_DISP,
    parameter int H_FRONT = vga_pkg::H_FRONT,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BACK  = vga_pkg::V_BACK,
    parameter int V_DISP  = vga_pkg::V_DISP,
    parameter int V_FRONT = vga_pkg::V_FRONT
) (
    input  logic                vga_clk,
    input  logic                sys_rst_n,
    vga_driver_if.master        pix_if,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_de,
    output vga_pkg::rgb_t       vga_rgb
);

    localparam int PW       = vga_pkg::POS_W;
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT_LO = H_SYNC + H_BACK;
    localparam int H_ACT_HI = H_ACT_LO + H_DISP;   // exclusive
    localparam int V_ACT_LO = V_SYNC + V_BACK;
    localparam int V_ACT_HI = V_ACT_LO + V_DISP;   // exclusive

    logic [PW-1:0]  r_h_cnt;
    logic [PW-1:0]  r_v_cnt;

    logic           w_h_last;
    logic           w_v_last;
    logic           w_h_act;
    logic           w_v_act;
    logic           w_active;
    logic           w_hsync_n;
    logic           w_vsync_n;
    logic [PW-1:0]  w_xpos;
    logic [PW-1:0]  w_ypos;
    vga_pkg::rgb_t  w_src_rgb;

    assign w_h_last = (r_h_cnt == PW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == PW'(V_TOTAL - 1));

    // Horizontal counter wraps every line; vertical advances only on the last pixel of a line
    // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + PW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + PW'(1);
        end
    end

    // Stage-0 decode, derived from registered counters only so the requests are glitch-free
    assign w_h_act   = (r_h_cnt >= PW'(H_ACT_LO)) && (r_h_cnt < PW'(H_ACT_HI));
    assign w_v_act   = (r_v_cnt >= PW'(V_ACT_LO)) && (r_v_cnt < PW'(V_ACT_HI));
    assign w_active  = w_h_act && w_v_act;
    assign w_hsync_n = !(r_h_cnt < PW'(H_SYNC));
    assign w_vsync_n = !(r_v_cnt < PW'(V_SYNC));

    // Positions are zero outside the window so the source sees a stable address during blanking
    assign w_xpos = w_active ? (r_h_cnt - PW'(H_ACT_LO)) : '0;
    assign w_ypos = w_active ? (r_v_cnt - PW'(V_ACT_LO)) : '0;

    assign pix_if.pixel_xpos = w_xpos;
    assign pix_if.pixel_ypos = w_ypos;

`ifdef VGA_COLORBAR_EN
    vga_colorbar #(
        .ACT_W (H_DISP)
    ) u_colorbar (
        .i_xpos (w_xpos),
        .o_rgb  (w_src_rgb)
    );
`else
    assign w_src_rgb = pix_if.pixel_data;
`endif

    // Output stage: all four signals registered together for one-cycle, mutually aligned latency
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_de  <= 1'b0;
            vga_rgb <= vga_pkg::BLACK;
        end else begin
            vga_hs  <= w_hsync_n;
            vga_vs  <= w_vsync_n;
            vga_de  <= w_active;
            vga_rgb <= w_active ? w_src_rgb : vga_pkg::BLACK;
        end
    end

endmodule

// File: tb/tb_vga_driver.sv
// Scoreboard bench for vga_driver: one instance at the 640x480 defaults and
// one with a tiny timing set so whole frames and both counter wraps are seen.
module tb_vga_driver;

    typedef struct {
        int hs, hb, hd, hf, vs, vb, vd, vf;
    } cfg_t;

    typedef struct {
        logic [46:0] exp;
        int          h;
        int          v;
    } item_t;

    // Observed vector layout: {hs, vs, de, rgb[23:0], xpos[9:0], ypos[9:0]}
    localparam logic [46:0] RESET_V = {1'b1, 1'b1, 1'b0, 24'h0, 10'h0, 10'h0};

    logic        clk;
    logic        rst_n;
    logic        tie;
    logic [23:0] noise;

    int pass_cnt  = 0;
    int total_cnt = 0;

    item_t       q [2][$];
    int          t [2];
    logic [46:0] obs [2];

    logic        hs0, vs0, de0, hs1, vs1, de1;
    logic [23:0] rgb0, rgb1;

    vga_driver_if pif0 ();
    vga_driver_if pif1 ();

    function automatic logic [23:0] pattern(logic [9:0] x, logic [9:0] y);
        return {6'b0, y, 8'b0} ^ {14'b0, x};
    endfunction

    assign pif0.pixel_data = tie ? 24'h123456 : (pattern(pif0.pixel_xpos, pif0.pixel_ypos) ^ noise);
    assign pif1.pixel_data = tie ? 24'h123456 : (pattern(pif1.pixel_xpos, pif1.pixel_ypos) ^ noise);

    vga_driver u_dut0 (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .pix_if    (pif0.master),
        .vga_hs    (hs0),
        .vga_vs    (vs0),
        .vga_de    (de0),
        .vga_rgb   (rgb0)
    );

    vga_driver #(
        .H_SYNC (4), .H_BACK (3), .H_DISP (16), .H_FRONT (2),
        .V_SYNC (2), .V_BACK (3), .V_DISP (6),  .V_FRONT (2)
    ) u_dut1 (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .pix_if    (pif1.master),
        .vga_hs    (hs1),
        .vga_vs    (vs1),
        .vga_de    (de1),
        .vga_rgb   (rgb1)
    );

    assign obs[0] = {hs0, vs0, de0, rgb0, pif0.pixel_xpos, pif0.pixel_ypos};
    assign obs[1] = {hs1, vs1, de1, rgb1, pif1.pixel_xpos, pif1.pixel_ypos};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cfg_t cfg_of(int k);
        cfg_t c;
        if (k == 0) c = '{96, 48, 640, 16, 2, 33, 480, 10};
        else        c = '{4, 3, 16, 2, 2, 3, 6, 2};
        return c;
    endfunction

    function automatic int h_total(cfg_t c);
        return c.hs + c.hb + c.hd + c.hf;
    endfunction

    function automatic int v_total(cfg_t c);
        return c.vs + c.vb + c.vd + c.vf;
    endfunction

    function automatic logic [23:0] bar_ref(int x, int hd);
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return bars[x / (hd / 8)];
    endfunction

    // Reference: position is (cycles since reset) folded by line and frame length
    function automatic logic [46:0] model(int k, int tc, logic tie_v, logic [23:0] nz);
        cfg_t        c;
        int          ht, vt, h, v, x, y, h2, v2, x2, y2;
        bit          act, act2;
        logic [23:0] rgb;
        logic [9:0]  xo, yo;
        c    = cfg_of(k);
        ht   = h_total(c);
        vt   = v_total(c);
        h    = tc % ht;
        v    = (tc / ht) % vt;
        x    = h - (c.hs + c.hb);
        y    = v - (c.vs + c.vb);
        act  = (x >= 0) && (x < c.hd) && (y >= 0) && (y < c.vd);
        h2   = (tc + 1) % ht;
        v2   = ((tc + 1) / ht) % vt;
        x2   = h2 - (c.hs + c.hb);
        y2   = v2 - (c.vs + c.vb);
        act2 = (x2 >= 0) && (x2 < c.hd) && (y2 >= 0) && (y2 < c.vd);
        rgb  = 24'h0;
        if (act) begin
`ifdef VGA_COLORBAR_EN
            rgb = bar_ref(x, c.hd);
`else
            rgb = tie_v ? 24'h123456 : (pattern(10'(x), 10'(y)) ^ nz);
`endif
        end
        xo = act2 ? 10'(x2) : 10'h0;
        yo = act2 ? 10'(y2) : 10'h0;
        return {(h >= c.hs), (v >= c.vs), act, rgb, xo, yo};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Stimulus side of the scoreboard: predict what each edge will produce
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            item_t it;
            if (!rst_n) begin
                it.exp = RESET_V;
                it.h   = 0;
                it.v   = 0;
                t[k]   = 0;
            end else begin
                cfg_t c;
                c      = cfg_of(k);
                it.exp = model(k, t[k], tie, noise);
                it.h   = t[k] % h_total(c);
                it.v   = (t[k] / h_total(c)) % v_total(c);
                t[k]   = t[k] + 1;
            end
            q[k].push_back(it);
        end
    end

    // Monitor: every cycle presents a new output word; pop and compare away from the edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            item_t it;
            if (q[k].size() == 0) begin
                total_cnt++;
                $display("FAIL dut%0d_queue: got empty expected an entry", k);
            end else begin
                it = q[k].pop_front();
                check($sformatf("dut%0d_out_h%0d_v%0d", k, it.h, it.v), 64'(obs[k]), 64'(it.exp));
            end
        end
    end

    // Frame statistics: pulse widths, pulses per frame, frame length, de count
    int   cyc [2], de_n [2], hsf [2], hlow [2], vlow [2], frames [2];
    bit   seen [2];
    logic phs [2], pvs [2];

    initial begin
        for (int k = 0; k < 2; k++) frames[k] = 0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cfg_t c;
            logic hs_o, vs_o, de_o;
            c    = cfg_of(k);
            hs_o = obs[k][46];
            vs_o = obs[k][45];
            de_o = obs[k][44];
            if (!rst_n) begin
                cyc[k] = 0; de_n[k] = 0; hsf[k] = 0; hlow[k] = 0; vlow[k] = 0;
                seen[k] = 1'b0; phs[k] = 1'b1; pvs[k] = 1'b1;
            end else begin
                if (pvs[k] && !vs_o) begin
                    if (seen[k]) begin
                        check($sformatf("dut%0d_frame_len", k), 64'(cyc[k]), 64'(h_total(c) * v_total(c)));
                        check($sformatf("dut%0d_de_count", k), 64'(de_n[k]), 64'(c.hd * c.vd));
                        check($sformatf("dut%0d_hs_pulses", k), 64'(hsf[k]), 64'(v_total(c)));
                        frames[k]++;
                    end
                    seen[k] = 1'b1;
                    cyc[k]  = 0;
                    de_n[k] = 0;
                    hsf[k]  = 0;
                end
                cyc[k]++;
                if (de_o) de_n[k]++;
                if (phs[k] && !hs_o) hsf[k]++;
                if (!hs_o) hlow[k]++;
                else begin
                    if (!phs[k]) check($sformatf("dut%0d_hs_width", k), 64'(hlow[k]), 64'(c.hs));
                    hlow[k] = 0;
                end
                if (!vs_o) vlow[k]++;
                else begin
                    if (!pvs[k]) check($sformatf("dut%0d_vs_width", k), 64'(vlow[k]), 64'(c.vs * h_total(c)));
                    vlow[k] = 0;
                end
                phs[k] = hs_o;
                pvs[k] = vs_o;
            end
        end
    end

    // Random source noise, changed away from the sampling edge
    initial begin
        noise = 24'h0;
        forever begin
            @(negedge clk);
            noise = 24'($urandom);
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        tie   = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;

        // Run the default instance past the first active line, then hit reset mid-line
        while (t[0] < 36 * 800 + 300) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_dut0", 64'(obs[0]), 64'(RESET_V));
        check("async_reset_dut1", 64'(obs[1]), 64'(RESET_V));
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Fresh frames after release: random data, then a tied source, then random again
        while (t[0] < 1600) @(negedge clk);
        #1 tie = 1'b1;
        while (t[0] < 3600) @(negedge clk);
        #1 tie = 1'b0;
        while (t[0] < 4600) @(negedge clk);

        @(negedge clk);
        #1;
        check("dut1_frames_seen_min", 64'(frames[1] >= 20), 64'(1));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
